// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEPTH_WORDS_DEF = 256;
  localparam int WAIT_STATES_DEF = 1;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: byte-enabled synchronous write, asynchronous read.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a programmable number of
// wait states between request acceptance and the response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int WAIT_STATES = WAIT_STATES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int               IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0]      DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;

  logic             we_p0;
  logic [31:0]      addr_p0;
  logic [31:0]      wdata_p0;
  logic [3:0]       be_p0;

  logic             accept;
  logic             commit;
  logic             acc_err;
  logic             mem_we;
  logic [IDX_W-1:0] widx;
  logic [31:0]      mem_rdata;

  // req_ready is forced low while reset is held, even though state is IDLE.
  assign req_ready = reset_n && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign commit    = (state == WAIT) && (cnt == '0);

  // Misaligned or beyond the last word: the access is rejected, memory untouched.
  assign acc_err   = (addr_p0[1:0] != 2'b00) || (addr_p0[31:2] >= DEPTH_LIM);
  assign widx      = addr_p0[IDX_W+1:2];
  assign mem_we    = commit && we_p0 && !acc_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .widx  (widx),
    .wdata (wdata_p0),
    .be    (be_p0),
    .ridx  (widx),
    .rdata (mem_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: accept -> wait out the counter -> hold response until taken.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Wait-state counter: loaded on accept, counts down to zero in WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= WAIT_INIT;
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Request latch stage: inputs are don't-care once captured here.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      be_p0    <= req_be;
    end
  end

  // Response stage: captured on the commit edge, held until the initiator takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (commit) begin
      rsp_valid <= 1'b1;
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_err || we_p0) ? 32'h0 : mem_rdata;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with WAIT_STATES 1, 3, 0.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n   [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (256),
      .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          acc_cyc  [3] = '{0, 0, 0};
  logic        prev_v   [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] model    [256];

  function automatic int ws_of(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 3 : 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every new response is popped from the scoreboard and compared.
  always @(negedge clk) begin
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      if (rsp_valid[s] === 1'b1 && prev_v[s] !== 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'(s), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("rsp_inst",    32'(s),              32'(e.inst));
          chk("rsp_rdata",   rsp_rdata[s],        e.rdata);
          chk("rsp_err",     32'(rsp_err[s]),     32'(e.err));
          chk("rsp_latency", 32'(cyc - acc_cyc[s]), 32'(e.lat));
        end
      end
      prev_v[s] <= rsp_valid[s];
    end
  end

  task automatic wait_ready(input int s);
    int n = 0;
    while (req_ready[s] !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) chk("timeout_req_ready", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int s);
    int n = 0;
    while (rsp_valid[s] !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) chk("timeout_rsp_valid", 32'd0, 32'd1);
  endtask

  // One complete transaction; bp > 0 holds rsp_ready low for bp cycles.
  task automatic txn(input int s, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_rd, input logic exp_err, input int bp);
    sb.push_back('{s, exp_rd, exp_err, ws_of(s) + 1});
    if (s == 0 && we && !exp_err) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
    end
    @(negedge clk);
    wait_ready(s);
    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    req_be[s]    = be;
    rsp_ready[s] = (bp == 0);
    @(posedge clk); #1;
    acc_cyc[s]   = cyc;
    req_valid[s] = 1'b0;
    req_we[s]    = ~we;
    req_addr[s]  = 32'hFFFF_FFFC;
    req_wdata[s] = ~wdata;
    req_be[s]    = 4'hF;
    wait_valid(s);
    if (bp > 0) begin
      for (int i = 0; i < bp; i++) begin
        chk("bp_rsp_valid", 32'(rsp_valid[s]), 32'd1);
        chk("bp_rsp_rdata", rsp_rdata[s], exp_rd);
        chk("bp_req_ready", 32'(req_ready[s]), 32'd0);
        @(negedge clk);
      end
      rsp_ready[s] = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", 32'(rsp_valid[s]), 32'd0);
      chk("bp_release_ready", 32'(req_ready[s]), 32'd1);
      rsp_ready[s] = 1'b0;
    end else begin
      @(posedge clk); #1;
      rsp_ready[s] = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[3];
    for (int s = 0; s < 3; s++) begin
      reset_n[s] = 1'b0; req_valid[s] = 1'b0; req_we[s] = 1'b0;
      req_addr[s] = '0; req_wdata[s] = '0; req_be[s] = '0; rsp_ready[s] = 1'b0;
    end
    for (int i = 0; i < 256; i++) model[i] = 32'h0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("rst_rsp_err",   32'(rsp_err[0]), 32'd0);
    for (int s = 0; s < 3; s++) reset_n[s] = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) chk("post_rst_ready", 32'(req_ready[s]), 32'd1);

    // Instance 0 (WAIT_STATES=1): initialise every word.
    for (int i = 0; i < 256; i++)
      txn(0, 1'b1, 32'(i * 4), 32'h5A00_0000 + 32'(i) * 32'h0001_0001, 4'hF, 32'h0, 1'b0, 0);

    // Full store then load.
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 0);
    txn(0, 1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 0);

    // Partial store, then an all-disabled store that must change nothing.
    txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0,         1'b0, 0);
    txn(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0, 0);
    txn(0, 1'b0, 32'h20, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0, 0);
    txn(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0, 0);
    txn(0, 1'b0, 32'h20, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0, 0);

    // Errors: misaligned load/store, out-of-range store and load.
    txn(0, 1'b0, 32'h22,  32'h0,         4'h0, 32'h0, 1'b1, 0);
    txn(0, 1'b1, 32'h12,  32'h0BAD_0BAD, 4'hF, 32'h0, 1'b1, 0);
    txn(0, 1'b1, 32'h400, 32'h0BAD_0BAD, 4'hF, 32'h0, 1'b1, 0);
    txn(0, 1'b0, 32'h400, 32'h0,         4'h0, 32'h0, 1'b1, 0);
    for (int i = 0; i < 256; i++)
      txn(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, model[i], 1'b0, 0);

    // Backpressure: response held for 5 cycles.
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 5);

    // Instance 1 (WAIT_STATES=3): reset while a store is waiting.
    txn(1, 1'b1, 32'h8, 32'h1234_5678, 4'hF, 32'h0,         1'b0, 0);
    txn(1, 1'b0, 32'h8, 32'h0,         4'h0, 32'h1234_5678, 1'b0, 0);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h8;
    req_wdata[1] = 32'hCAFE_F00D; req_be[1] = 4'hF; rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    reset_n[1] = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready[1]), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata[1], 32'd0);
    chk("midrst_rsp_err",   32'(rsp_err[1]), 32'd0);
    repeat (2) @(negedge clk);
    reset_n[1] = 1'b1;
    rsp_ready[1] = 1'b0;
    #1;
    chk("midrst_release_ready", 32'(req_ready[1]), 32'd1);
    repeat (6) @(negedge clk);
    chk("midrst_no_rsp", 32'(rsp_valid[1]), 32'd0);
    txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 0);

    // Instance 2 (WAIT_STATES=0): single-edge latency, then back-to-back loads.
    txn(2, 1'b1, 32'h4, 32'h0BAD_F00D, 4'hF, 32'h0,         1'b0, 0);
    txn(2, 1'b0, 32'h4, 32'h0,         4'h0, 32'h0BAD_F00D, 1'b0, 0);
    for (int i = 0; i < 3; i++) sb.push_back('{2, 32'h0BAD_F00D, 1'b0, 1});
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'h4;
    req_be[2] = 4'h0; rsp_ready[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready(2);
      @(posedge clk); #1;
      acc_cyc[2] = cyc;
      acc[i]     = cyc;
      @(negedge clk);
    end
    req_valid[2] = 1'b0;
    repeat (4) @(negedge clk);
    rsp_ready[2] = 1'b0;
    chk("b2b_spacing_1", 32'(acc[1] - acc[0]), 32'd3);
    chk("b2b_spacing_2", 32'(acc[2] - acc[1]), 32'd3);

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
